// File: rtl/mux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// mux_sel_ctrl
//
// Generates the select line for a downstream 2:1 data mux. A raw, bouncing
// pushbutton is synchronised and debounced, and each debounced press toggles
// `sel`. Two more modes are available: AUTO sweeps `sel` periodically, and
// FORCED pins `sel` to `force_val`.
//
// Parameters
//   DB_CYCLES   : consecutive stable synchronised cycles needed before the
//                 debounced level changes (>= 1)
//   AUTO_PERIOD : cycles between automatic toggles in AUTO mode (>= 2)
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active high
//   btn         : raw pushbutton (asynchronous, may bounce)
//   auto_en     : request AUTO mode
//   force_en    : request FORCED mode (has priority over auto_en)
//   force_val   : value driven onto sel while FORCED
//   sel         : registered mux select (0 = i0, 1 = i1)
//   sel_changed : registered, high in every cycle where sel differs from its
//                 previous-cycle value
//   btn_clean   : registered debounced button level
//   mode        : registered mode: 00 MANUAL, 01 AUTO, 10 FORCED
// -----------------------------------------------------------------------------
module mux_sel_ctrl #(
    parameter int DB_CYCLES   = 4,
    parameter int AUTO_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       auto_en,
    input  logic       force_en,
    input  logic       force_val,
    output logic       sel,
    output logic       sel_changed,
    output logic       btn_clean,
    output logic [1:0] mode
);

    // A single-cycle debounce still needs a 1-bit counter to stay legal.
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int AUTO_W = $clog2(AUTO_PERIOD);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_FORCED = 2'b10
    } mode_e;

    // Two-flop synchroniser: only the next flop in the chain looks at btn and s1.
    logic              s1_q, s1_d;
    logic              btn_s_q, btn_s_d;

    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              btn_clean_q, btn_clean_d;
    logic              btn_clean_dly_q, btn_clean_dly_d;

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              sel_q, sel_d;
    logic              sel_changed_q, sel_changed_d;
    mode_e             mode_q, mode_d;

    logic              press;

    // Single-cycle pulse on the debounced rising edge; release produces nothing.
    assign press = btn_clean_q & ~btn_clean_dly_q;

    always_comb begin
        s1_d            = btn;
        btn_s_d         = s1_q;
        btn_clean_dly_d = btn_clean_q;

        // A return to the current clean level before the threshold throws the
        // partial count away, which is what rejects bounce.
        btn_clean_d = btn_clean_q;
        db_cnt_d    = '0;
        if (btn_s_q != btn_clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_clean_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Mode is decoded from the live requests; the same decode drives this
        // edge's action and becomes the registered mode.
        if (force_en) begin
            mode_d = MODE_FORCED;
        end else if (auto_en) begin
            mode_d = MODE_AUTO;
        end else begin
            mode_d = MODE_MANUAL;
        end

        sel_d      = sel_q;
        auto_cnt_d = '0;
        unique case (mode_d)
            MODE_FORCED: begin
                // Presses are dropped here, not queued for later.
                sel_d = force_val;
            end
            MODE_AUTO: begin
                // A press coinciding with the terminal count still yields one toggle.
                if (press || (auto_cnt_q == AUTO_LAST)) begin
                    sel_d = ~sel_q;
                end else begin
                    auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                end
            end
            default: begin
                if (press) begin
                    sel_d = ~sel_q;
                end
            end
        endcase

        sel_changed_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q            <= 1'b0;
            btn_s_q         <= 1'b0;
            db_cnt_q        <= '0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
            auto_cnt_q      <= '0;
            sel_q           <= 1'b0;
            sel_changed_q   <= 1'b0;
            mode_q          <= MODE_MANUAL;
        end else begin
            s1_q            <= s1_d;
            btn_s_q         <= btn_s_d;
            db_cnt_q        <= db_cnt_d;
            btn_clean_q     <= btn_clean_d;
            btn_clean_dly_q <= btn_clean_dly_d;
            auto_cnt_q      <= auto_cnt_d;
            sel_q           <= sel_d;
            sel_changed_q   <= sel_changed_d;
            mode_q          <= mode_d;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = sel_changed_q;
    assign btn_clean   = btn_clean_q;
    assign mode        = mode_q;

endmodule
